// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - nibble-stream command sequencer driving the 3-bit ALU, with a small result buffer
// Collects opcode/A/B nibbles, holds them on the ALU inputs, and queues the ALU result for a downstream consumer.
module alu_cmd_sequencer #(
  parameter int DATA_W    = 3,
  parameter int RES_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_data,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [1:0]                   alu_opcode,
  input  logic [DATA_W:0]              alu_z,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W:0]              out_z,
  output logic [$clog2(RES_DEPTH):0]   res_count
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_pend_op;
  logic [DATA_W-1:0] r_pend_a;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [1:0]        r_alu_op;

  logic [DATA_W:0]   r_mem [RES_DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_count;

  logic w_accept;
  logic w_clear;
  logic w_pop;
  logic w_full;
  logic w_push;

  assign in_ready = (r_state != S_EXEC);
  assign w_accept = in_valid && in_ready;
  assign w_clear  = w_accept && (r_state == S_OP) && in_data[3];
  assign w_pop    = out_valid && out_ready;
  assign w_full   = (r_count == CW'(RES_DEPTH));
  // A full buffer can still take the result when the head leaves on the same edge.
  assign w_push   = (r_state == S_EXEC) && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OP;
      r_pend_op <= 2'b00;
      r_pend_a  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= 2'b00;
    end else begin
      case (r_state)
        S_OP: begin
          if (w_accept && !in_data[3]) begin
            r_pend_op <= in_data[1:0];
            r_state   <= S_A;
          end
        end
        S_A: begin
          if (w_accept) begin
            r_pend_a <= in_data[DATA_W-1:0];
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (w_accept) begin
            r_alu_op <= r_pend_op;
            r_alu_a  <= r_pend_a;
            r_alu_b  <= in_data[DATA_W-1:0];
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_push) begin
            r_state <= S_OP;
          end
        end
        default: r_state <= S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      // Flush beats any simultaneous pop; a push cannot happen outside S_EXEC.
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= alu_z;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign out_valid  = (r_count != '0);
  assign out_z      = r_mem[r_rd];
  assign res_count  = r_count;

endmodule
